// File: rtl/mcpu_if.sv
// ---------------------------------------------------------------------------
// mcpu_if -- word-wide memory bus between the mcpu control path and its
// unified instruction/data RAM.
//
// Signals:
//   addr   word address (fetch address or load/store address)
//   we     write strobe, write happens on the rising clock edge
//   wdata  store data
//   rdata  combinational read data for addr
//
// Modports:
//   master  the CPU side (drives addr/we/wdata, samples rdata)
//   slave   the RAM side (samples addr/we/wdata, drives rdata)
// ---------------------------------------------------------------------------
interface mcpu_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
) ();
    logic [ADDR_SIZE-1:0] addr;
    logic                 we;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/mcpu.sv
// ---------------------------------------------------------------------------
// mcpu -- minimal 16-bit multi-cycle von-Neumann microprocessor.
//
// Every instruction takes two cycles: FETCH loads IR from mem[PC] and bumps
// PC, EXECUTE performs the register/memory/branch effect. OP_HALT parks the
// FSM in HALTED until reset.
//
// Ports:
//   clk    input  rising-edge clock
//   reset  input  synchronous active-high reset (PC=0, IR=0, state=FETCH)
//
// Sub-instances (hierarchically loaded by software/benches):
//   raminst.mem[0:RAM_SIZE-1]   unified instruction/data memory
//   regfileinst.R[0:15]         register file, R0 is an ordinary register
//
// Configuration macro:
//   MCPU_MULDIV_EN  when defined, OP_MUL and OP_DIV are implemented; when not
//                   defined they execute as NOP and no multiplier/divider
//                   is built.
// ---------------------------------------------------------------------------

// Unified RAM: combinational read, synchronous write, not cleared by reset.
module mcpu_ram #(
    parameter int WORD_SIZE = 16,
    parameter int RAM_SIZE  = 256
) (
    input logic   clk,
    mcpu_if.slave bus
);
    logic [WORD_SIZE-1:0] mem [0:RAM_SIZE-1];

    assign bus.rdata = mem[bus.addr];

    // Store port: write lands on the edge so the next cycle's read sees it.
    always_ff @(posedge clk) begin
        if (bus.we) begin
            mem[bus.addr] <= bus.wdata;
        end
    end
endmodule

// Register file: two combinational read ports, one synchronous write port.
module mcpu_regfile #(
    parameter int WORD_SIZE    = 16,
    parameter int OPERAND_SIZE = 4
) (
    input  logic                    clk,
    input  logic [OPERAND_SIZE-1:0] raddr1,
    input  logic [OPERAND_SIZE-1:0] raddr2,
    input  logic [OPERAND_SIZE-1:0] waddr,
    input  logic                    we,
    input  logic [WORD_SIZE-1:0]    wdata,
    output logic [WORD_SIZE-1:0]    rdata1,
    output logic [WORD_SIZE-1:0]    rdata2
);
    logic [WORD_SIZE-1:0] R [0:(1<<OPERAND_SIZE)-1];

    assign rdata1 = R[raddr1];
    assign rdata2 = R[raddr2];

    // Write port: result of the EXECUTE cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            R[waddr] <= wdata;
        end
    end
endmodule

module mcpu #(
    parameter int WORD_SIZE        = 16,
    parameter int OPCODE_SIZE      = 4,
    parameter int OPERAND_SIZE     = 4,
    parameter int INSTRUCTION_SIZE = 16,
    parameter int RAM_SIZE         = 256,
    parameter logic [3:0] OP_NOP           = 4'd0,
    parameter logic [3:0] OP_AND           = 4'd1,
    parameter logic [3:0] OP_OR            = 4'd2,
    parameter logic [3:0] OP_XOR           = 4'd3,
    parameter logic [3:0] OP_ADD           = 4'd4,
    parameter logic [3:0] OP_SUB           = 4'd5,
    parameter logic [3:0] OP_MUL           = 4'd6,
    parameter logic [3:0] OP_DIV           = 4'd7,
    parameter logic [3:0] OP_SHORT_TO_REG  = 4'd8,
    parameter logic [3:0] OP_LOAD_FROM_MEM = 4'd9,
    parameter logic [3:0] OP_STORE_TO_MEM  = 4'd10,
    parameter logic [3:0] OP_BNZ           = 4'd11,
    parameter logic [3:0] OP_BZ            = 4'd12,
    parameter logic [3:0] OP_JMP           = 4'd13,
    parameter logic [3:0] OP_HALT          = 4'd15
) (
    input logic clk,
    input logic reset
);
    localparam int ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [ADDR_SIZE-1:0]          pc_r;
    logic [ADDR_SIZE-1:0]          pc_next_s;
    logic [INSTRUCTION_SIZE-1:0]   ir_r;
    logic [INSTRUCTION_SIZE-1:0]   ir_next_s;

    // Instruction fields: {opcode, A, B, C}; the low byte doubles as imm8/addr8.
    logic [OPCODE_SIZE-1:0]        opcode_s;
    logic [OPERAND_SIZE-1:0]       a_s;
    logic [OPERAND_SIZE-1:0]       b_s;
    logic [OPERAND_SIZE-1:0]       c_s;
    logic [ADDR_SIZE-1:0]          imm_s;

    assign opcode_s = ir_r[INSTRUCTION_SIZE-1 -: OPCODE_SIZE];
    assign a_s      = ir_r[3*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign b_s      = ir_r[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign c_s      = ir_r[OPERAND_SIZE-1:0];
    assign imm_s    = ir_r[ADDR_SIZE-1:0];

    // Register file hookup.
    logic [OPERAND_SIZE-1:0]       rf_raddr1_s;
    logic [WORD_SIZE-1:0]          rf_rdata1_s;
    logic [WORD_SIZE-1:0]          rf_rdata2_s;
    logic                          rf_we_s;
    logic [WORD_SIZE-1:0]          rf_wdata_s;
    logic [WORD_SIZE-1:0]          alu_s;
    logic                          three_reg_s;

    mcpu_if #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) mbus ();

    mcpu_ram #(
        .WORD_SIZE (WORD_SIZE),
        .RAM_SIZE  (RAM_SIZE)
    ) raminst (
        .clk (clk),
        .bus (mbus.slave)
    );

    mcpu_regfile #(
        .WORD_SIZE    (WORD_SIZE),
        .OPERAND_SIZE (OPERAND_SIZE)
    ) regfileinst (
        .clk    (clk),
        .raddr1 (rf_raddr1_s),
        .raddr2 (c_s),
        .waddr  (a_s),
        .we     (rf_we_s),
        .wdata  (rf_wdata_s),
        .rdata1 (rf_rdata1_s),
        .rdata2 (rf_rdata2_s)
    );

    // Port 1 reads B for three-register ops and A (store data / branch test) otherwise.
    always_comb begin
        three_reg_s = 1'b0;
        case (opcode_s)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV: three_reg_s = 1'b1;
            default:                                               three_reg_s = 1'b0;
        endcase
        if (three_reg_s) begin
            rf_raddr1_s = b_s;
        end else begin
            rf_raddr1_s = a_s;
        end
    end

    // ALU: R[B] op R[C], all arithmetic modulo 2^WORD_SIZE.
    always_comb begin
        alu_s = {WORD_SIZE{1'b0}};
        case (opcode_s)
            OP_AND: alu_s = rf_rdata1_s & rf_rdata2_s;
            OP_OR:  alu_s = rf_rdata1_s | rf_rdata2_s;
            OP_XOR: alu_s = rf_rdata1_s ^ rf_rdata2_s;
            OP_ADD: alu_s = rf_rdata1_s + rf_rdata2_s;
            OP_SUB: alu_s = rf_rdata1_s - rf_rdata2_s;
`ifdef MCPU_MULDIV_EN
            OP_MUL: alu_s = rf_rdata1_s * rf_rdata2_s;
            OP_DIV: begin
                // Divide by zero saturates to all ones instead of trapping.
                if (rf_rdata2_s == {WORD_SIZE{1'b0}}) begin
                    alu_s = {WORD_SIZE{1'b1}};
                end else begin
                    alu_s = rf_rdata1_s / rf_rdata2_s;
                end
            end
`endif
            default: alu_s = {WORD_SIZE{1'b0}};
        endcase
    end

    // Control FSM next-state, PC/IR update and write strobes.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        ir_next_s    = ir_r;
        mbus.addr    = pc_r;
        mbus.we      = 1'b0;
        mbus.wdata   = rf_rdata1_s;
        rf_we_s      = 1'b0;
        rf_wdata_s   = alu_s;

        case (state_r)
            FETCH: begin
                ir_next_s    = mbus.rdata;
                pc_next_s    = pc_r + 8'd1;
                state_next_s = EXECUTE;
            end
            EXECUTE: begin
                state_next_s = FETCH;
                mbus.addr    = imm_s;
                case (opcode_s)
                    OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: rf_we_s = 1'b1;
`ifdef MCPU_MULDIV_EN
                    OP_MUL, OP_DIV: rf_we_s = 1'b1;
`endif
                    OP_SHORT_TO_REG: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = {{(WORD_SIZE-ADDR_SIZE){1'b0}}, imm_s};
                    end
                    OP_LOAD_FROM_MEM: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = mbus.rdata;
                    end
                    OP_STORE_TO_MEM: mbus.we = 1'b1;
                    OP_BNZ: begin
                        if (rf_rdata1_s != {WORD_SIZE{1'b0}}) begin
                            pc_next_s = imm_s;
                        end else begin
                            pc_next_s = pc_r;
                        end
                    end
                    OP_BZ: begin
                        if (rf_rdata1_s == {WORD_SIZE{1'b0}}) begin
                            pc_next_s = imm_s;
                        end else begin
                            pc_next_s = pc_r;
                        end
                    end
                    OP_JMP:  pc_next_s    = imm_s;
                    OP_HALT: state_next_s = HALTED;
                    // NOP, reserved opcode and (when disabled) MUL/DIV: PC already advanced.
                    default: state_next_s = FETCH;
                endcase
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = FETCH;
        endcase

        // A write pending in the cycle reset is sampled must not land.
        if (reset) begin
            mbus.we = 1'b0;
            rf_we_s = 1'b0;
        end else begin
            mbus.we = mbus.we;
            rf_we_s = rf_we_s;
        end
    end

    // State, PC and IR registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= 8'd0;
            ir_r    <= {INSTRUCTION_SIZE{1'b0}};
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            ir_r    <= ir_next_s;
        end
    end
endmodule

// File: tb/tb_mcpu.sv
// ---------------------------------------------------------------------------
// tb_mcpu -- directed self-checking bench for mcpu. Programs and registers are
// loaded through raminst.mem[] / regfileinst.R[] while reset is held.
// Expected architectural state is queued as each program is set up and
// compared once it has run; stores to mem[100] are checked in order by a
// monitor against a second queue.
// ---------------------------------------------------------------------------
module tb_mcpu;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mcpu dut (
        .clk   (clk),
        .reset (reset)
    );

    localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_STATE = 3, K_IR = 4;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] store_q[$];
    int          total = 0;
    int          fails = 0;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    function automatic logic [15:0] insi(input logic [3:0] op, input logic [3:0] a,
                                         input logic [7:0] imm);
        return {op, a, imm};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int kind, input int idx);
        case (kind)
            K_REG:   return dut.regfileinst.R[idx];
            K_MEM:   return dut.raminst.mem[idx];
            K_PC:    return {8'd0, dut.pc_r};
            K_STATE: return {14'd0, dut.state_r};
            K_IR:    return dut.ir_r;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int kind, input int idx, input logic [15:0] val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.kind, e.idx), e.val);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for one edge and wipe memory and registers.
    task automatic begin_test();
        reset = 1'b1;
        run(1);
        for (int i = 0; i < 256; i++) dut.raminst.mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) dut.regfileinst.R[i] = 16'h0000;
    endtask

    task automatic wait_halt(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (dut.state_r != 2'd2 && n < max_cycles) begin
            run(1);
            n++;
        end
        chk(tag, {14'd0, dut.state_r}, 16'd2);
    endtask

    task automatic load_hail(input logic [15:0] n);
        dut.raminst.mem[0]  = insi(4'd9, 4'd1, 8'd100);
        dut.raminst.mem[1]  = insi(4'd8, 4'd2, 8'd1);
        dut.raminst.mem[2]  = insi(4'd8, 4'd4, 8'd2);
        dut.raminst.mem[3]  = insi(4'd8, 4'd5, 8'd3);
        dut.raminst.mem[4]  = insi(4'd8, 4'd6, 8'd1);
        dut.raminst.mem[5]  = ins(4'd5, 4'd3, 4'd1, 4'd2);
        dut.raminst.mem[6]  = insi(4'd11, 4'd3, 8'd8);
        dut.raminst.mem[7]  = insi(4'd11, 4'd6, 8'd21);
        dut.raminst.mem[8]  = ins(4'd1, 4'd7, 4'd1, 4'd2);
        dut.raminst.mem[9]  = insi(4'd11, 4'd7, 8'd14);
        dut.raminst.mem[10] = ins(4'd7, 4'd1, 4'd1, 4'd4);
        dut.raminst.mem[11] = insi(4'd10, 4'd1, 8'd100);
        dut.raminst.mem[12] = insi(4'd13, 4'd0, 8'd5);
        dut.raminst.mem[14] = ins(4'd6, 4'd1, 4'd1, 4'd5);
        dut.raminst.mem[15] = ins(4'd4, 4'd1, 4'd1, 4'd2);
        dut.raminst.mem[16] = insi(4'd10, 4'd1, 8'd100);
        dut.raminst.mem[17] = insi(4'd13, 4'd0, 8'd5);
        dut.raminst.mem[21] = insi(4'd15, 4'd0, 8'd0);
        dut.raminst.mem[100] = n;
    endtask

    // Store monitor: every write to mem[100] must match the next queued value.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset && dut.mbus.we && dut.mbus.addr == 8'd100) begin
            if (store_q.size() > 0) e = store_q.pop_front();
            else                    e = 16'hxxxx;
            chk("store_mem100", dut.mbus.wdata, e);
        end
    end

    initial begin
        // Reset state, then SHORT_TO_REG
        begin_test();
        expect_v("rst_pc", K_PC, 0, 16'h0000);
        expect_v("rst_ir", K_IR, 0, 16'h0000);
        expect_v("rst_state", K_STATE, 0, 16'h0000);
        drain();
        dut.raminst.mem[0] = insi(4'd8, 4'd2, 8'h2A);
        expect_v("short_r2", K_REG, 2, 16'h002A);
        expect_v("short_pc", K_PC, 0, 16'h0001);
        reset = 1'b0;
        run(2);
        drain();

        // ALU, load/store, reserved opcode, HALT
        begin_test();
        dut.regfileinst.R[1]  = 16'h1234;
        dut.regfileinst.R[2]  = 16'h5555;
        dut.regfileinst.R[8]  = 16'hF0F0;
        dut.regfileinst.R[9]  = 16'h0FF0;
        dut.regfileinst.R[10] = 16'h0007;
        dut.regfileinst.R[11] = 16'h0000;
        dut.regfileinst.R[12] = 16'h0100;
        dut.regfileinst.R[13] = 16'hFFFF;
        dut.regfileinst.R[14] = 16'h0001;
        dut.regfileinst.R[15] = 16'h7777;
        dut.raminst.mem[201] = 16'hBEEF;
        dut.raminst.mem[0]  = ins(4'd7, 4'd1, 4'd10, 4'd11);
        dut.raminst.mem[1]  = ins(4'd6, 4'd2, 4'd12, 4'd12);
        dut.raminst.mem[2]  = ins(4'd4, 4'd3, 4'd13, 4'd14);
        dut.raminst.mem[3]  = ins(4'd1, 4'd4, 4'd8, 4'd9);
        dut.raminst.mem[4]  = ins(4'd2, 4'd5, 4'd8, 4'd9);
        dut.raminst.mem[5]  = ins(4'd3, 4'd6, 4'd8, 4'd9);
        dut.raminst.mem[6]  = ins(4'd5, 4'd7, 4'd14, 4'd13);
        dut.raminst.mem[7]  = ins(4'd7, 4'd15, 4'd8, 4'd9);
        dut.raminst.mem[8]  = insi(4'd10, 4'd5, 8'd200);
        dut.raminst.mem[9]  = insi(4'd9, 4'd0, 8'd201);
        dut.raminst.mem[10] = ins(4'd14, 4'd9, 4'd1, 4'd2);
        dut.raminst.mem[11] = insi(4'd15, 4'd0, 8'd0);
`ifdef MCPU_MULDIV_EN
        expect_v("div_by_zero", K_REG, 1, 16'hFFFF);
        expect_v("mul_wrap", K_REG, 2, 16'h0000);
        expect_v("div_trunc", K_REG, 15, 16'h000F);
`else
        expect_v("div_is_nop", K_REG, 1, 16'h1234);
        expect_v("mul_is_nop", K_REG, 2, 16'h5555);
        expect_v("div2_is_nop", K_REG, 15, 16'h7777);
`endif
        expect_v("add_wrap", K_REG, 3, 16'h0000);
        expect_v("and", K_REG, 4, 16'h00F0);
        expect_v("or", K_REG, 5, 16'hFFF0);
        expect_v("xor", K_REG, 6, 16'hFF00);
        expect_v("sub_wrap", K_REG, 7, 16'h0002);
        expect_v("store", K_MEM, 200, 16'hFFF0);
        expect_v("load_r0", K_REG, 0, 16'hBEEF);
        expect_v("reserved_nop", K_REG, 9, 16'h0FF0);
        expect_v("halt_pc", K_PC, 0, 16'h000C);
        reset = 1'b0;
        wait_halt("alu_halted", 100);
        drain();
        run(10);
        expect_v("halt_pc_frozen", K_PC, 0, 16'h000C);
        drain();

        // Untaken BZ/BNZ, HALT at 3, restart after reset
        begin_test();
        dut.regfileinst.R[2] = 16'h0005;
        dut.raminst.mem[0] = insi(4'd12, 4'd2, 8'd5);
        dut.raminst.mem[1] = insi(4'd11, 4'd1, 8'd5);
        dut.raminst.mem[2] = insi(4'd8, 4'd3, 8'h11);
        dut.raminst.mem[3] = insi(4'd15, 4'd0, 8'd0);
        dut.raminst.mem[5] = insi(4'd8, 4'd3, 8'hEE);
        dut.raminst.mem[6] = insi(4'd15, 4'd0, 8'd0);
        expect_v("untaken_r3", K_REG, 3, 16'h0011);
        expect_v("halt3_pc", K_PC, 0, 16'h0004);
        reset = 1'b0;
        wait_halt("halt3", 50);
        drain();
        run(20);
        expect_v("halt3_pc_frozen", K_PC, 0, 16'h0004);
        expect_v("halt3_state_frozen", K_STATE, 0, 16'h0002);
        drain();
        reset = 1'b1;
        run(1);
        expect_v("halt_reset_pc", K_PC, 0, 16'h0000);
        expect_v("halt_reset_state", K_STATE, 0, 16'h0000);
        drain();
        reset = 1'b0;
        wait_halt("halt3_rerun", 50);
        expect_v("halt3_rerun_pc", K_PC, 0, 16'h0004);
        drain();

        // Taken BZ
        begin_test();
        dut.raminst.mem[0]  = insi(4'd12, 4'd1, 8'd9);
        dut.raminst.mem[1]  = insi(4'd8, 4'd4, 8'h55);
        dut.raminst.mem[9]  = insi(4'd8, 4'd4, 8'h77);
        dut.raminst.mem[10] = insi(4'd15, 4'd0, 8'd0);
        expect_v("bz_taken_r4", K_REG, 4, 16'h0077);
        expect_v("bz_taken_pc", K_PC, 0, 16'h000B);
        reset = 1'b0;
        wait_halt("bz_halted", 50);
        drain();

        // PC wrap 255 -> 0
        begin_test();
        dut.raminst.mem[0]   = insi(4'd13, 4'd0, 8'd254);
        dut.raminst.mem[254] = insi(4'd8, 4'd9, 8'h99);
        expect_v("pc_at_255", K_PC, 0, 16'h00FF);
        expect_v("wrap_r9", K_REG, 9, 16'h0099);
        reset = 1'b0;
        run(4);
        drain();
        run(1);
        expect_v("pc_wrap0", K_PC, 0, 16'h0000);
        expect_v("wrap_state", K_STATE, 0, 16'h0001);
        drain();

        // Store into next fetch, then reset during EXECUTE of ADD
        begin_test();
        dut.regfileinst.R[1] = 16'hAAAA;
        dut.regfileinst.R[2] = 16'h0005;
        dut.regfileinst.R[3] = 16'h0006;
        dut.regfileinst.R[5] = 16'h863C;
        dut.raminst.mem[0] = insi(4'd10, 4'd5, 8'd1);
        dut.raminst.mem[2] = ins(4'd4, 4'd1, 4'd2, 4'd3);
        expect_v("ir_is_add", K_IR, 0, 16'h4123);
        reset = 1'b0;
        run(5);
        drain();
        reset = 1'b1;
        run(1);
        expect_v("rst_exec_r1", K_REG, 1, 16'hAAAA);
        expect_v("rst_exec_pc", K_PC, 0, 16'h0000);
        expect_v("rst_exec_state", K_STATE, 0, 16'h0000);
        expect_v("self_mod_r6", K_REG, 6, 16'h003C);
        expect_v("self_mod_mem1", K_MEM, 1, 16'h863C);
        drain();

        // Hailstone n=1: BNZ at 6 not taken, BNZ at 7 to 21, no stores
        begin_test();
        load_hail(16'h0001);
        expect_v("hail1_mem100", K_MEM, 100, 16'h0001);
        expect_v("hail1_pc", K_PC, 0, 16'h0016);
        expect_v("hail1_r3", K_REG, 3, 16'h0000);
        expect_v("hail1_r7", K_REG, 7, 16'h0000);
        reset = 1'b0;
        wait_halt("hail1_halted", 200);
        drain();

`ifdef MCPU_MULDIV_EN
        // Hailstone n=6
        begin_test();
        load_hail(16'h0006);
        store_q = '{16'd3, 16'd10, 16'd5, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
        expect_v("hail6_mem100", K_MEM, 100, 16'h0001);
        expect_v("hail6_pc", K_PC, 0, 16'h0016);
        expect_v("hail6_r6", K_REG, 6, 16'h0001);
        reset = 1'b0;
        wait_halt("hail6_halted", 2000);
        drain();
        chk("hail6_stores_left", 16'(store_q.size()), 16'h0000);
`endif

        reset = 1'b1;
        run(1);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
